mem_bridge: RTL and testbench
=============================

MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TMO, default 255: memory-ack timeout in cycles, range 2..1023.
REQ-002 Parameter IOBASE, default 24'hFFFFC0: first byte address of the 64-byte I/O window.
REQ-003 clk  in  1  single clock, all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 adr  in  24  CPU byte address.
REQ-006 rd  in  1  CPU load strobe, one cycle.
REQ-007 wr  in  1  CPU store strobe, one cycle.
REQ-008 ben  in  1  CPU byte-access flag.
REQ-009 outbus  in  32  CPU store data, byte already replicated to its lane.
REQ-010 inbus  out  32  load data to CPU.
REQ-011 stallX  out  1  CPU stall request.
REQ-012 mem_req  out  1  memory request, held until ack.
REQ-013 mem_we  out  1  memory write (1) / read (0).
REQ-014 mem_adr  out  22  memory word address, adr[23:2].
REQ-015 mem_be  out  4  memory byte enables, active-high.
REQ-016 mem_wdata  out  32  memory write data.
REQ-017 mem_rdata  in  32  memory read data, valid with mem_ack.
REQ-018 mem_ack  in  1  memory completion, one cycle.
REQ-019 io_adr  out  4  I/O register index, adr[5:2].
REQ-020 io_rd  out  1  I/O read strobe.
REQ-021 io_wr  out  1  I/O write strobe.
REQ-022 io_wdata  out  32  I/O write data, equal to outbus.
REQ-023 io_rdata  in  32  I/O read data.

Function
REQ-024 An access is I/O when adr >= IOBASE; otherwise it is memory.
REQ-025 FSM states: IDLE, BUSY; stallX SHALL be 1 exactly when the state is BUSY, decoded from registered state only, never combinationally from rd, wr or adr.
REQ-026 In IDLE, on rd or wr to memory: latch mem_adr = adr[23:2], mem_we = wr, mem_wdata = outbus, and mem_be; enter BUSY; assert mem_req from the next cycle.
REQ-027 mem_be: when ben=0, 4'b1111; when ben=1, one-hot 1 << adr[1:0].
REQ-028 In BUSY, mem_req, mem_we, mem_adr, mem_be and mem_wdata SHALL stay constant until the cycle mem_ack=1 is sampled.
REQ-029 On mem_ack in BUSY: for a read, rdreg <= mem_rdata; for a write, rdreg is unchanged; deassert mem_req and return to IDLE. stallX is therefore 0 in the following cycle.
REQ-030 Minimum memory access: rd in cycle 0, stallX=1 and mem_req=1 in cycle 1, mem_ack in cycle 1, stallX=0 and inbus valid in cycle 2.
REQ-031 Read-data formatting: inbus = rdreg always. Byte extraction is done by the CPU, so the bridge SHALL NOT shift bytes.
REQ-032 I/O access: io_rd = rd and io_wr = wr, combinationally gated by the I/O decode and by state==IDLE; io_adr = adr[5:2].
REQ-033 On an I/O read, rdreg <= io_rdata at the end of the same cycle. There is no stall, and the data is presented on inbus in the next cycle.
REQ-034 Timeout counter: cleared on entering BUSY; increments each BUSY cycle without mem_ack.
REQ-035 On timeout, when the counter reaches TMO-1 without ack: rdreg <= 32'hFFFFFFFF (reads only), drop mem_req, return to IDLE, pulse sticky flag tmo_err (internal, cleared only by rst).
REQ-036 mem_ack in IDLE SHALL be ignored.
REQ-037 mem_ack in the same cycle as the timeout SHALL complete normally: ack wins.
REQ-038 rd or wr asserted while BUSY SHALL be ignored (the CPU gates rd and wr by stallX).
REQ-039 rd and wr asserted together in IDLE SHALL be treated as a write.
REQ-040 Back-to-back accesses: a new rd or wr in the first IDLE cycle after completion SHALL start without an extra idle cycle.
REQ-041 Address wrap: adr 24'hFFFFFF is I/O; adr 24'hFFFFBF is memory, giving mem_adr 22'h3FFFEF.

Reset
REQ-042 While rst=1 (asynchronously): state=IDLE, stallX=0, mem_req=0, mem_we=0, mem_adr=0, mem_be=0, mem_wdata=0, rdreg=0 (inbus=0), timeout counter=0, tmo_err=0.
REQ-043 rst asserted during BUSY SHALL abandon the access immediately; mem_req SHALL fall in the reset cycle, without waiting for clk.
REQ-044 The first access after rst deasserts SHALL be accepted on the first rising edge of clk.

Verification
REQ-045 Memory read, ack in cycle 1.
- Stimulus: adr=24'h000104, rd=1 in cycle 0; mem_rdata=32'hDEADBEEF with ack in cycle 1.
- Response: mem_adr=22'h000041, mem_be=4'hF, stallX=1 in cycle 1 only, inbus=32'hDEADBEEF in cycle 2.
REQ-046 Byte write with delayed ack.
- Stimulus: adr=24'h000203, wr=1, ben=1, outbus=32'h5A5A5A5A; ack in cycle 4.
- Response: mem_be=4'b1000, mem_we=1, inputs stable cycles 1..4, stallX=1 cycles 1..4, 0 in cycle 5.
REQ-047 I/O read.
- Stimulus: adr=24'hFFFFC4, rd=1, io_rdata=32'h00000077.
- Response: io_rd=1 in cycle 0, io_adr=4'h1, stallX never 1, inbus=32'h00000077 in cycle 1, mem_req never 1.
REQ-048 Timeout with TMO=4.
- Stimulus: read with no ack.
- Response: stallX=1 cycles 1..4, mem_req=0 and stallX=0 from cycle 5, inbus=32'hFFFFFFFF, tmo_err=1.
REQ-049 Reset mid-access.
- Stimulus: rst pulsed between clock edges in BUSY cycle 2.
- Response: mem_req and stallX fall immediately, inbus=0; a read issued after release completes normally.
REQ-050 Back-to-back.
- Stimulus: read acked in cycle 1, then a write issued in cycle 2.
- Response: mem_req=1 again in cycle 3 with mem_we=1.

Source files
------------

// File: rtl/mem_bridge.sv
// CPU-to-memory/I-O bridge: stalls the CPU across acked memory accesses and
// answers I/O-window accesses combinationally. An unacked access times out after TMO cycles.
module mem_bridge #(
  parameter int          TMO    = 255,
  parameter logic [23:0] IOBASE = 24'hFFFFC0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] adr,
  input  logic        rd,
  input  logic        wr,
  input  logic        ben,
  input  logic [31:0] outbus,
  output logic [31:0] inbus,
  output logic        stallX,
  output logic        mem_req,
  output logic        mem_we,
  output logic [21:0] mem_adr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  io_adr,
  output logic        io_rd,
  output logic        io_wr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [9:0] TLIM = 10'(TMO - 1);

  state_t      state;
  logic [9:0]  cnt;
  logic [31:0] rdreg;
  logic        tmo_err;
  logic        is_io;
  logic        idle;

  assign is_io    = (adr >= IOBASE);
  assign idle     = (state == IDLE);
  assign stallX   = (state == BUSY);
  assign inbus    = rdreg;
  assign io_adr   = adr[5:2];
  assign io_wdata = outbus;
  // A simultaneous rd+wr is a store, so it must not also fire an I/O read.
  assign io_rd    = rd & ~wr & is_io & idle;
  assign io_wr    = wr & is_io & idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdreg     <= '0;
      tmo_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE) begin
      if ((rd || wr) && !is_io) begin
        state     <= BUSY;
        cnt       <= '0;
        mem_req   <= 1'b1;
        mem_we    <= wr;
        mem_adr   <= adr[23:2];
        mem_wdata <= outbus;
        mem_be    <= ben ? (4'b0001 << adr[1:0]) : 4'b1111;
      end else if (io_rd) begin
        rdreg <= io_rdata;
      end
    end else begin
      // Ack is checked first so an ack landing on the last allowed cycle still wins.
      if (mem_ack) begin
        if (!mem_we) rdreg <= mem_rdata;
        mem_req <= 1'b0;
        state   <= IDLE;
      end else if (cnt == TLIM) begin
        if (!mem_we) rdreg <= 32'hFFFFFFFF;
        mem_req <= 1'b0;
        tmo_err <= 1'b1;
        state   <= IDLE;
      end else begin
        cnt <= cnt + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed and randomized bench for mem_bridge against a transaction-level model.
module tb_mem_bridge;

  localparam int          TMO    = 4;
  localparam logic [23:0] IOBASE = 24'hFFFFC0;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] adr;
  logic        rd, wr, ben;
  logic [31:0] outbus, inbus;
  logic        stallX, mem_req, mem_we;
  logic [21:0] mem_adr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [3:0]  io_adr;
  logic        io_rd, io_wr;
  logic [31:0] io_wdata, io_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdreg;
  logic        exp_tmo;

  mem_bridge #(.TMO(TMO), .IOBASE(IOBASE)) dut (
    .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .ben(ben),
    .outbus(outbus), .inbus(inbus), .stallX(stallX), .mem_req(mem_req),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .io_adr(io_adr), .io_rd(io_rd),
    .io_wr(io_wr), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // kind: 0 = load, 1 = store, 2 = load+store (a store). d: BUSY-cycle index of
  // the ack; d >= TMO means the memory never answers.
  task automatic mem_access(input logic [23:0] a, input int kind, input logic b,
                            input logic [31:0] wd, input logic [31:0] rdat, input int d);
    logic       is_wr;
    logic [3:0] be;
    int         len;
    is_wr = (kind != 0);
    case (a[1:0])
      2'd0: be = 4'b0001;
      2'd1: be = 4'b0010;
      2'd2: be = 4'b0100;
      default: be = 4'b1000;
    endcase
    if (!b) be = 4'b1111;
    len = (d < TMO) ? d + 1 : TMO;
    adr = a; rd = (kind != 1); wr = (kind != 0); ben = b; outbus = wd;
    #1;
    check("c0_stall", 32'(stallX), 32'd0);
    check("c0_req", 32'(mem_req), 32'd0);
    check("c0_io_strobes", 32'({io_rd, io_wr}), 32'd0);
    tick();
    for (int k = 0; k < len; k++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      adr = 24'($urandom);
      outbus = $urandom;
      ben = 1'($urandom_range(0, 1));
      mem_ack = (k == d);
      mem_rdata = (k == d) ? rdat : $urandom;
      #1;
      check("busy_stall", 32'(stallX), 32'd1);
      check("busy_req", 32'(mem_req), 32'd1);
      check("busy_we", 32'(mem_we), 32'(is_wr));
      check("busy_adr", 32'(mem_adr), 32'(a[23:2]));
      check("busy_be", 32'(mem_be), 32'(be));
      check("busy_wdata", mem_wdata, wd);
      check("busy_io_strobes", 32'({io_rd, io_wr}), 32'd0);
      tick();
    end
    rd = 1'b0; wr = 1'b0; mem_ack = 1'b0;
    if (!is_wr) exp_rdreg = (d < TMO) ? rdat : 32'hFFFFFFFF;
    if (d >= TMO) exp_tmo = 1'b1;
    #1;
    check("done_stall", 32'(stallX), 32'd0);
    check("done_req", 32'(mem_req), 32'd0);
    check("done_inbus", inbus, exp_rdreg);
    check("done_tmo_err", 32'(dut.tmo_err), 32'(exp_tmo));
  endtask

  task automatic io_access(input logic [23:0] a, input int kind,
                           input logic [31:0] wd, input logic [31:0] rdat);
    adr = a; rd = (kind == 0); wr = (kind != 0); outbus = wd; io_rdata = rdat;
    ben = 1'($urandom_range(0, 1));
    #1;
    check("io_rd", 32'(io_rd), 32'(kind == 0));
    check("io_wr", 32'(io_wr), 32'(kind != 0));
    check("io_adr", 32'(io_adr), 32'(a[5:2]));
    check("io_wdata", io_wdata, wd);
    check("io_c0_stall", 32'(stallX), 32'd0);
    tick();
    rd = 1'b0; wr = 1'b0; io_rdata = $urandom;
    if (kind == 0) exp_rdreg = rdat;
    #1;
    check("io_inbus", inbus, exp_rdreg);
    check("io_c1_stall", 32'(stallX), 32'd0);
    check("io_c1_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1; adr = '0; rd = 1'b0; wr = 1'b0; ben = 1'b0; outbus = '0;
    mem_rdata = '0; mem_ack = 1'b0; io_rdata = '0;
    exp_rdreg = '0; exp_tmo = 1'b0;
    #3;
    check("rst_inbus", inbus, 32'd0);
    check("rst_stall", 32'(stallX), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_adr", 32'(mem_adr), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_tmo_err", 32'(dut.tmo_err), 32'd0);
    tick();
    rst = 1'b0;

    // Minimum-latency read, then a store issued in the very next cycle.
    mem_access(24'h000104, 0, 1'b0, 32'h0, 32'hDEADBEEF, 0);
    check("rd_min_adr_const", 32'(mem_adr), 32'h41);
    mem_access(24'h000300, 1, 1'b0, 32'hCAFEF00D, 32'h0, 0);
    // Byte store, ack in cycle 4 (coincides with the timeout limit: ack wins).
    mem_access(24'h000203, 1, 1'b1, 32'h5A5A5A5A, 32'h0, 3);
    check("byte_wr_be", 32'(mem_be), 32'h8);
    check("byte_wr_no_tmo", 32'(dut.tmo_err), 32'd0);
    io_access(24'hFFFFC4, 0, 32'h0, 32'h00000077);
    // Ack while idle must not disturb the read register.
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    #1;
    check("idle_ack_inbus", inbus, exp_rdreg);
    check("idle_ack_stall", 32'(stallX), 32'd0);
    mem_access(24'h000010, 0, 1'b0, 32'h0, 32'h11111111, TMO + 2);
    mem_access(24'hFFFFBF, 0, 1'b1, 32'h0, 32'h0BADC0DE, 1);
    check("wrap_mem_adr", 32'(mem_adr), 32'h3FFFEF);
    io_access(24'hFFFFFF, 1, 32'h99887766, 32'h0);
    mem_access(24'h000020, 2, 1'b0, 32'hA5A5A5A5, 32'h22222222, 1);

    // Reset pulsed between edges in the second BUSY cycle.
    adr = 24'h000400; rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_stall", 32'(stallX), 32'd0);
    check("mid_rst_inbus", inbus, 32'd0);
    check("mid_rst_tmo_err", 32'(dut.tmo_err), 32'd0);
    rst = 1'b0;
    exp_rdreg = '0; exp_tmo = 1'b0;
    #1;
    mem_access(24'h000444, 0, 1'b0, 32'h0, 32'h31415926, 2);

    for (int i = 0; i < 60; i++) begin
      logic [23:0] a;
      if ($urandom_range(0, 3) == 0) begin
        a = IOBASE + 24'($urandom_range(0, 63));
        io_access(a, int'($urandom_range(0, 1)), $urandom, $urandom);
      end else begin
        a = ($urandom_range(0, 7) == 0) ? 24'hFFFFBF : 24'($urandom_range(0, 32'(IOBASE) - 1));
        mem_access(a, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, int'($urandom_range(0, TMO + 2)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
